// File: rtl/filt_cicd_ctrl.sv
// Sequencing controller for a CIC decimation filter: input handshake, phase tracking,
// result capture into a one-entry buffer, and zero-flush. Optional stats: FILT_CICD_CTRL_STATS_EN.
module filt_cicd_ctrl #(
    parameter int gp_decimation_factor = 4,
    parameter int gp_phase             = 0,
    parameter int gp_inp_width         = 8,
    parameter int gp_oup_width         = 14,
    parameter int gp_cic_latency       = 1,
    parameter int gp_flush_len         = 12
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_flush,
    input  logic                           i_in_valid,
    output logic                           o_in_ready,
    input  logic signed [gp_inp_width-1:0] i_in_data,
    output logic                           o_cic_ena,
    output logic signed [gp_inp_width-1:0] o_cic_data,
    input  logic signed [gp_oup_width-1:0] i_cic_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic signed [gp_oup_width-1:0] o_data,
    output logic                           o_busy,
`ifdef FILT_CICD_CTRL_STATS_EN
    output logic [15:0]                    o_in_count,
    output logic [15:0]                    o_out_count,
`endif
    output logic                           o_done
);

    localparam int PW = (gp_decimation_factor > 2) ? $clog2(gp_decimation_factor) : 1;
    localparam int FW = $clog2(gp_flush_len + 1);
    localparam int L  = gp_cic_latency;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t          state;
    logic [PW-1:0]   phase;
    logic [L-1:0]    pending;
    logic [L-1:0]    pending_nxt;
    logic [FW-1:0]   flush_cnt;
    logic            stall;
    logic            capture;
    logic            xfer;

    assign stall   = (o_valid & ~i_ready) | (|pending);
    assign capture = pending[L-1];
    assign xfer    = o_valid & i_ready;
    assign o_busy  = (state != IDLE);

    always_comb begin
        o_in_ready = 1'b0;
        o_cic_ena  = 1'b0;
        o_cic_data = '0;
        case (state)
            RUN: begin
                o_in_ready = ~stall;
                o_cic_ena  = i_in_valid & ~stall;
                o_cic_data = i_in_data;
            end
            FLUSH: begin
                o_cic_ena  = ~stall & (flush_cnt < FW'(gp_flush_len));
            end
            default: ;
        endcase
    end

    // Phase hit marks the pushed sample whose filter result is taken L cycles later.
    always_comb begin
        pending_nxt    = pending << 1;
        pending_nxt[0] = o_cic_ena & (phase == PW'(gp_phase));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            phase     <= '0;
            pending   <= '0;
            flush_cnt <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_done    <= 1'b0;
        end else begin
            o_done  <= 1'b0;
            pending <= pending_nxt;
            if (o_cic_ena)
                phase <= (phase == PW'(gp_decimation_factor - 1)) ? '0 : phase + 1'b1;
            if (capture) begin
                o_data  <= i_cic_data;
                o_valid <= 1'b1;
            end else if (xfer) begin
                o_valid <= 1'b0;
            end
            case (state)
                IDLE: if (i_start) state <= RUN;
                RUN: if (i_flush) begin
                    state     <= FLUSH;
                    flush_cnt <= '0;
                end
                FLUSH: begin
                    if (o_cic_ena)
                        flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == FW'(gp_flush_len) && pending == '0) begin
                        state  <= IDLE;
                        o_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FILT_CICD_CTRL_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst || (state == IDLE && i_start)) begin
            o_in_count  <= '0;
            o_out_count <= '0;
        end else begin
            if (state == RUN && o_cic_ena)
                o_in_count <= o_in_count + 16'd1;
            if (xfer)
                o_out_count <= o_out_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_filt_cicd_ctrl.sv
// Directed self-checking bench for filt_cicd_ctrl (R=4, phase 0, latency 1, flush 12).
module tb_filt_cicd_ctrl;

    logic               clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_start = 1'b0;
    logic               i_flush = 1'b0;
    logic               i_in_valid = 1'b0;
    logic               o_in_ready;
    logic signed [7:0]  i_in_data = '0;
    logic               o_cic_ena;
    logic signed [7:0]  o_cic_data;
    logic signed [13:0] cic_q = '0;
    logic               o_valid;
    logic               i_ready = 1'b1;
    logic signed [13:0] o_data;
    logic               o_busy;
    logic               o_done;
`ifdef FILT_CICD_CTRL_STATS_EN
    logic [15:0]        o_in_count;
    logic [15:0]        o_out_count;
`endif

    int vectors = 0;
    int fails   = 0;
    int k = 1, kmax = 0;
    int zeros = 0, done_cnt = 0;
    logic acc;
    logic [13:0] got[$];
    bit exp_rdy[10] = '{1, 0, 1, 1, 1, 1, 0, 1, 1, 1};
    bit exp_v[10]   = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

    always #5 clk = ~clk;

    // One-cycle filter stand-in: output is the last pushed sample, sign-extended.
    always @(posedge clk) if (o_cic_ena) cic_q <= {{6{o_cic_data[7]}}, o_cic_data};

    filt_cicd_ctrl #(
        .gp_decimation_factor(4), .gp_phase(0), .gp_inp_width(8),
        .gp_oup_width(14), .gp_cic_latency(1), .gp_flush_len(12)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_flush(i_flush),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .o_cic_ena(o_cic_ena), .o_cic_data(o_cic_data), .i_cic_data(cic_q),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_busy(o_busy),
`ifdef FILT_CICD_CTRL_STATS_EN
        .o_in_count(o_in_count), .o_out_count(o_out_count),
`endif
        .o_done(o_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        i_in_valid = (k <= kmax);
        i_in_data  = 8'(3 * k);
    endtask

    // Record this cycle's observations, advance one clock, drive the next inputs.
    task automatic cyc();
        if (o_valid && i_ready) got.push_back(o_data);
        if (o_done) done_cnt++;
        if (o_cic_ena && !o_in_ready) begin
            zeros++;
            chk("flush_zero_data", 32'(o_cic_data), 0);
        end
        acc = o_cic_ena && o_in_ready;
        @(posedge clk);
        #1;
        if (acc) k++;
        drive();
        #1;
    endtask

    initial begin
        // Reset and IDLE behaviour
        repeat (2) cyc();
        i_rst = 1'b0;
        k = 1; kmax = 8; drive(); #1;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("idle_ready", 32'(o_in_ready), 0);
        chk("idle_ena", 32'(o_cic_ena), 0);
        i_flush = 1'b1; cyc(); i_flush = 1'b0;
        chk("idle_flush_ignored", 32'(o_busy), 0);
        i_start = 1'b1; cyc(); i_start = 1'b0;
        chk("start_busy", 32'(o_busy), 1);

        // Test 1: 8 samples, downstream always ready
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("t1_ready_c%0d", c), 32'(o_in_ready), 32'(exp_rdy[c]));
            chk($sformatf("t1_ena_c%0d", c), 32'(o_cic_ena), 32'(exp_rdy[c]));
            chk($sformatf("t1_valid_c%0d", c), 32'(o_valid), 32'(exp_v[c]));
            cyc();
        end
        cyc();
        chk("t1_count", 32'(got.size()), 2);
        chk("t1_res0", 32'(got[0]), 3);
        chk("t1_res1", 32'(got[1]), 15);
        chk("t1_all_taken", 32'(k), 9);

        // Test 2: same stream with downstream stalled
        got.delete();
        k = 1; kmax = 8; i_ready = 1'b0; drive(); #1;
        chk("t2_ena_c0", 32'(o_cic_ena), 1);
        cyc();
        chk("t2_ready_c1", 32'(o_in_ready), 0);
        cyc();
        for (int c = 2; c < 6; c++) begin
            chk($sformatf("t2_hold_ready_c%0d", c), 32'(o_in_ready), 0);
            chk($sformatf("t2_hold_valid_c%0d", c), 32'(o_valid), 1);
            chk($sformatf("t2_hold_data_c%0d", c), 32'(o_data), 3);
            cyc();
        end
        i_ready = 1'b1; #1;
        chk("t2_release_ready", 32'(o_in_ready), 1);
        for (int n = 0; n < 40 && (k <= kmax || o_valid); n++) cyc();
        chk("t2_count", 32'(got.size()), 2);
        chk("t2_res0", 32'(got[0]), 3);
        chk("t2_res1", 32'(got[1]), 15);
        chk("t2_all_taken", 32'(k), 9);

        // Test 3: flush on the 3rd handshake; phase starts at 0 so results are s1 then zeros at pushes 5, 9, 13
        got.delete(); zeros = 0; done_cnt = 0;
        k = 1; kmax = 8; drive(); #1;
        for (int n = 0; n < 20 && !(k == 3 && o_cic_ena); n++) cyc();
        chk("t3_third_hs", 32'(o_cic_ena), 1);
        i_flush = 1'b1; cyc(); i_flush = 1'b0;
        kmax = 3; drive(); #1;
        chk("t3_third_taken", 32'(k), 4);
        chk("t3_flush_busy", 32'(o_busy), 1);
        chk("t3_flush_ready", 32'(o_in_ready), 0);
        for (int n = 0; n < 80 && done_cnt == 0; n++) cyc();
        repeat (5) cyc();
        chk("t3_zeros", 32'(zeros), 12);
        chk("t3_done_pulses", 32'(done_cnt), 1);
        chk("t3_idle", 32'(o_busy), 0);
        chk("t3_count", 32'(got.size()), 4);
        chk("t3_res0", 32'(got[0]), 3);
        chk("t3_res1", 32'(got[1]), 0);
        chk("t3_res3", 32'(got[3]), 0);

        // Test 4: reset in the middle of a flush
        k = 1; kmax = 1; drive();
        i_start = 1'b1; cyc(); i_start = 1'b0;
        for (int n = 0; n < 10 && k < 2; n++) cyc();
        i_flush = 1'b1; cyc(); i_flush = 1'b0;
        zeros = 0;
        for (int n = 0; n < 40 && zeros < 5; n++) cyc();
        chk("t4_five_zeros", 32'(zeros), 5);
        i_rst = 1'b1; cyc();
        chk("t4_busy", 32'(o_busy), 0);
        chk("t4_valid", 32'(o_valid), 0);
        chk("t4_data", 32'(o_data), 0);
        chk("t4_done", 32'(o_done), 0);
        chk("t4_ready", 32'(o_in_ready), 0);
        chk("t4_ena", 32'(o_cic_ena), 0);
        i_rst = 1'b0;
        k = 1; kmax = 1; i_ready = 1'b0; drive();
        i_start = 1'b1; cyc(); i_start = 1'b0;
        chk("t4_first_push", 32'(o_cic_ena), 1);
        cyc();
        chk("t4_capture_stall", 32'(o_in_ready), 0);
        cyc();
        chk("t4_valid_after", 32'(o_valid), 1);
        chk("t4_data_after", 32'(o_data), 3);

`ifdef FILT_CICD_CTRL_STATS_EN
        i_rst = 1'b1; cyc(); i_rst = 1'b0;
        i_ready = 1'b1; k = 1; kmax = 70000; drive();
        i_start = 1'b1; cyc(); i_start = 1'b0;
        for (int n = 0; n < 100000 && k <= kmax; n++) cyc();
        repeat (6) cyc();
        chk("stats_in", 32'(o_in_count), 4464);
        chk("stats_out", 32'(o_out_count), 17500);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
